seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative shift-and-subtract (restoring) divider. It is the inverse-direction companion of the sum-and-shift multiplier datapath.
- Accepts a dividend/divisor pair on a start pulse. Produces one quotient bit per clock, then presents quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic unit and shares its start/done handshake style toward the control FSM.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (minimum 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high in ITER and DONE states
done  output  1  one-cycle pulse; results valid while high and held afterwards
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Reset is synchronous, active-low. On any clk edge with reset=0:
  - state goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and all internal registers clear to 0.
  - This applies mid-operation too. The in-flight division is discarded and no done is produced.
- State IDLE:
  - start=1 and divisor!=0 at edge N:
    - latch divisor into dvsr.
    - q_sh = dividend; rem_acc (WIDTH+1 bits) = 0; iteration counter = WIDTH-1.
    - go to ITER.
  - start=1 and divisor==0 at edge N: go to DONE and register the results:
    - quotient = all ones.
    - remainder = dividend.
    - div_by_zero = 1.
  - start=0: remain in IDLE.
- State ITER, one bit per cycle:
  - trial = {rem_acc[WIDTH-1:0], q_sh[WIDTH-1]} - {1'b0, dvsr}, computed in WIDTH+1 bits.
  - If trial MSB = 0: rem_acc = trial and q_sh shifts left with 1 in the LSB.
  - Otherwise: rem_acc = {rem_acc[WIDTH-1:0], q_sh[WIDTH-1]} and q_sh shifts left with 0 in the LSB.
  - Counter decrements each cycle. The iteration done at counter==0 (edge N+WIDTH) also writes quotient = q_sh result, remainder = rem_acc[WIDTH-1:0] and div_by_zero = 0, and moves to DONE.
- State DONE:
  - done=1 for exactly this cycle.
  - Next edge returns to IDLE unconditionally.
  - start is ignored here.
- Latency:
  - Normal: done high in the cycle after edge N+WIDTH.
  - Zero divisor: done high in the cycle after edge N.
  - Back-to-back: a new start is accepted 1 cycle after done drops, i.e. in IDLE.
- start while busy=1 is ignored and does not corrupt the operation in flight.
- dividend and divisor may change freely after the start edge.
- quotient, remainder and div_by_zero hold their values until the next completed operation or reset. They are not cleared on a new start.
- Arithmetic is unsigned, with quotient = floor(a/b) and remainder = a mod b, unless the optional feature is enabled.
- No overflow is possible in unsigned mode.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN
- Defined:
  - Operands are two's complement.
  - At start, record sign_q = dividend[MSB] ^ divisor[MSB] and sign_r = dividend[MSB], then iterate on the magnitudes. A WIDTH-bit magnitude of the most negative value is treated as unsigned.
  - On the final ITER edge, negate the quotient if sign_q and the remainder if sign_r. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative / -1 yields quotient = most-negative and remainder = 0, with no flag.
  - Zero divisor: quotient = all ones, remainder = dividend.
  - Latency is unchanged.
- Undefined: purely unsigned operation as described above. No sign logic is synthesized.

Test Plan (WIDTH=8):
- Reset, then start with 100 / 7 -> done exactly 1 cycle after edge N+8; quotient=14, remainder=2, div_by_zero=0; busy high from edge N to done cycle inclusive.
- 255 / 1, then 3 / 200 back-to-back (second start in first IDLE cycle after done) -> 255 r 0, then 0 r 3; outputs hold between operations.
- 5 / 0 -> done in cycle after start edge; quotient=0xFF, remainder=5, div_by_zero=1; next 9 / 3 -> 3 r 0 with div_by_zero=0.
- Start 100 / 7, pulse start with 50 / 5 at iteration 3 -> ignored; result 14 r 2; exactly one done pulse.
- Start 100 / 7, reset=0 for one edge at iteration 4 -> next cycle all outputs 0, busy=0, no done; then 200 / 13 -> 15 r 5.
- Signed, macro defined:
  - 0xF9 / 0x02 (-7/2) -> quotient=0xFD (-3), remainder=0xFF (-1).
  - 0x80 / 0xFF -> quotient=0x80, remainder=0x00.
  - Same 0xF9 / 0x02 with macro undefined -> 124 r 1.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring (shift-and-subtract) divider.
// One quotient bit is produced per clock; results are presented with a
// one-cycle done pulse and held until the next completed operation or reset.
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   defined   -> two's complement operands; the sign is recorded at start,
//                magnitudes are iterated, and the results are negated at the end
//   undefined -> purely unsigned operation; no sign logic is built
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   start        request, sampled only in IDLE
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high in ITER and DONE
//   done         one-cycle pulse when results become valid
//   quotient     result quotient (held)
//   remainder    result remainder (held)
//   div_by_zero  set with done when the divisor was 0 (held)
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIter = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] q_sh_q, q_sh_d;
    logic [WIDTH:0]   rem_acc_q, rem_acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // The accumulator MSB only ever holds a transient borrow; it is never read back.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_acc_q[WIDTH];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sign_q_q, sign_q_d;
    logic sign_r_q, sign_r_d;
`endif

    always_comb begin
        shifted  = {rem_acc_q[WIDTH-1:0], q_sh_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvsr_q};
        // A clear borrow bit means the divisor fits: keep the difference, emit a 1.
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial : shifted;
        q_next   = {q_sh_q[WIDTH-2:0], q_bit};
`ifdef SEQ_DIVIDER_SIGNED_EN
        // The most negative value maps to itself, which is its correct unsigned magnitude.
        a_mag    = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        b_mag    = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        q_final  = sign_q_q ? (~q_next + 1'b1) : q_next;
        r_final  = sign_r_q ? (~rem_next[WIDTH-1:0] + 1'b1) : rem_next[WIDTH-1:0];
`else
        a_mag    = dividend;
        b_mag    = divisor;
        q_final  = q_next;
        r_final  = rem_next[WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        dvsr_d      = dvsr_q;
        q_sh_d      = q_sh_q;
        rem_acc_d   = rem_acc_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end else begin
                        dvsr_d    = b_mag;
                        q_sh_d    = a_mag;
                        rem_acc_d = '0;
                        cnt_d     = CntW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        sign_q_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_d  = dividend[WIDTH-1];
`endif
                        state_d   = StIter;
                    end
                end
            end
            StIter: begin
                rem_acc_d = rem_next;
                q_sh_d    = q_next;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quotient_d  = q_final;
                    remainder_d = r_final;
                    dbz_d       = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            dvsr_q      <= '0;
            q_sh_q      <= '0;
            rem_acc_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dvsr_q      <= dvsr_d;
            q_sh_q      <= q_sh_d;
            rem_acc_q   <= rem_acc_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
`endif
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8): stimulus pushes expected results
// computed with plain integer arithmetic; a negedge monitor checks busy, done
// timing, results and output hold.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           neg_cnt = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_dbz = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        e.due = 0;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa    = $signed(a);
            sbv   = $signed(b);
            e.q   = W'(sa / sbv);
            e.r   = W'(sa % sbv);
`else
            sa    = int'(a);
            sbv   = int'(b);
            e.q   = W'(sa / sbv);
            e.r   = W'(sa % sbv);
`endif
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every negedge, compare against the scoreboard and held values.
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt = neg_cnt + 1;
            if (!reset) begin
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_done", 32'(done), 32'd0);
                chk("reset_quot", 32'(quotient), 32'd0);
                chk("reset_rem", 32'(remainder), 32'd0);
                chk("reset_dbz", 32'(div_by_zero), 32'd0);
            end else begin
                chk("busy", 32'(busy), 32'(sb.size() != 0));
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 32'(done), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("done_latency", 32'(neg_cnt), 32'(e.due));
                        chk("quotient", 32'(quotient), 32'(e.q));
                        chk("remainder", 32'(remainder), 32'(e.r));
                        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                        last_q   = e.q;
                        last_r   = e.r;
                        last_dbz = e.dbz;
                    end
                end else begin
                    chk("hold_quot", 32'(quotient), 32'(last_q));
                    chk("hold_rem", 32'(remainder), 32'(last_r));
                    chk("hold_dbz", 32'(div_by_zero), 32'(last_dbz));
                    if (sb.size() != 0 && neg_cnt > sb[0].due) begin
                        chk("missing_done", 32'(neg_cnt), 32'(sb[0].due));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e        = model(a, b);
        e.due    = neg_cnt + ((b == 0) ? 1 : W + 1);
        sb.push_back(e);
        @(negedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk("wait_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        issue(a, b);
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;

        run(8'd100, 8'd7);
        run(8'd255, 8'd1);
        run(8'd3, 8'd200);
        run(8'd5, 8'd0);
        run(8'd9, 8'd3);

        // start pulse during iteration must be ignored
        issue(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        #1;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // reset mid-operation discards the division
        issue(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        last_q   = '0;
        last_r   = '0;
        last_dbz = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        run(8'd200, 8'd13);

        run(8'hF9, 8'h02);
        run(8'h80, 8'hFF);
        run(8'h80, 8'h01);
        run(8'h00, 8'h05);
        run(8'hFF, 8'hFF);

        for (int i = 0; i < 250; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            run(a, b);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
